jesd204_tx_sync_monitor: RTL and testbench

Per-link classifier for the JESD204B TX SYNC~ request. It consumes the already-synchronised, active-low sync_n bits from the two-flop synchroniser stage in the clk domain. It decides, per link, whether a low excursion is an error report (short) or a resynchronisation request (long), then reports link status, single-cycle event pulses and saturating error counters to the TX link FSM and register map.

---
 rtl/jesd204_tx_sync_monitor_if.sv | 25 ++
 rtl/jesd204_tx_sync_monitor.sv | 134 +++++++++++++
 tb/tb_jesd204_tx_sync_monitor.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/jesd204_tx_sync_monitor_if.sv
// SYNC~ monitor bus: link controls and synchronised SYNC~ in, link status, event pulses
// and error counters out. The master side drives the inputs; the monitor is the slave.
interface jesd204_tx_sync_monitor_if #(
  parameter int NUM_LINKS     = 1,
  parameter int ERR_CNT_WIDTH = 8
);
  logic                               enable;
  logic [NUM_LINKS-1:0]               sync_n;
  logic                               err_cnt_clr;
  logic [NUM_LINKS-1:0]               link_synced;
  logic                               sync_all;
  logic [NUM_LINKS-1:0]               resync_req;
  logic [NUM_LINKS-1:0]               err_pulse;
  logic [NUM_LINKS*ERR_CNT_WIDTH-1:0] err_cnt;

  modport master (
    output enable, sync_n, err_cnt_clr,
    input  link_synced, sync_all, resync_req, err_pulse, err_cnt
  );

  modport slave (
    input  enable, sync_n, err_cnt_clr,
    output link_synced, sync_all, resync_req, err_pulse, err_cnt
  );
endinterface

// File: rtl/jesd204_tx_sync_monitor.sv
// Per-link JESD204B TX SYNC~ classifier: a short low run is an error report, a long one
// is a resync request. Provides link status, event pulses and saturating error counters.
module jesd204_tx_sync_monitor #(
  parameter int NUM_LINKS     = 1,
  parameter int RESYNC_CYCLES = 16,
  parameter int ERR_CNT_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     resetn,
  jesd204_tx_sync_monitor_if.slave bus
);

  localparam int                     CW       = $clog2(RESYNC_CYCLES + 1);
  localparam logic [CW-1:0]          LOW_ONE  = CW'(1);
  localparam logic [CW-1:0]          LOW_LAST = CW'(RESYNC_CYCLES - 1);
  localparam logic [ERR_CNT_WIDTH-1:0] ERR_ONE = ERR_CNT_WIDTH'(1);
  localparam logic [ERR_CNT_WIDTH-1:0] ERR_MAX = {ERR_CNT_WIDTH{1'b1}};

  typedef enum logic [1:0] {
    WAIT_SYNC   = 2'd0,
    SYNCED      = 2'd1,
    LOW_PENDING = 2'd2,
    RESYNC      = 2'd3
  } state_t;

  state_t                   r_state       [NUM_LINKS];
  state_t                   w_state_nxt   [NUM_LINKS];
  logic [CW-1:0]            r_low_cnt     [NUM_LINKS];
  logic [CW-1:0]            w_low_cnt_nxt [NUM_LINKS];
  logic [ERR_CNT_WIDTH-1:0] r_err_cnt     [NUM_LINKS];
  logic [ERR_CNT_WIDTH-1:0] w_err_cnt_nxt [NUM_LINKS];
  logic [NUM_LINKS-1:0]     w_resync;
  logic [NUM_LINKS-1:0]     w_err;
  logic [NUM_LINKS-1:0]     w_synced_nxt;
  logic [NUM_LINKS-1:0]     r_link_synced;
  logic [NUM_LINKS-1:0]     r_resync_req;
  logic [NUM_LINKS-1:0]     r_err_pulse;
  logic                     r_sync_all;

  // Next-state, low-run length, event and error-count logic for every link.
  always_comb begin
    for (int i = 0; i < NUM_LINKS; i++) begin
      w_state_nxt[i]   = r_state[i];
      w_low_cnt_nxt[i] = r_low_cnt[i];
      w_resync[i]      = 1'b0;
      w_err[i]         = 1'b0;
      // Disabling overrides any classification landing on the same edge.
      if (!bus.enable) begin
        w_state_nxt[i]   = WAIT_SYNC;
        w_low_cnt_nxt[i] = '0;
      end else begin
        case (r_state[i])
          WAIT_SYNC: begin
            if (bus.sync_n[i]) w_state_nxt[i] = SYNCED;
            else               w_state_nxt[i] = WAIT_SYNC;
          end
          SYNCED: begin
            if (!bus.sync_n[i]) begin
              w_state_nxt[i]   = LOW_PENDING;
              w_low_cnt_nxt[i] = LOW_ONE;
            end else begin
              w_state_nxt[i]   = SYNCED;
            end
          end
          LOW_PENDING: begin
            if (bus.sync_n[i]) begin
              w_state_nxt[i]   = SYNCED;
              w_err[i]         = 1'b1;
              w_low_cnt_nxt[i] = '0;
            end else if (r_low_cnt[i] == LOW_LAST) begin
              w_state_nxt[i]   = RESYNC;
              w_resync[i]      = 1'b1;
              w_low_cnt_nxt[i] = '0;
            end else begin
              w_low_cnt_nxt[i] = r_low_cnt[i] + LOW_ONE;
            end
          end
          RESYNC: begin
            if (bus.sync_n[i]) w_state_nxt[i] = SYNCED;
            else               w_state_nxt[i] = RESYNC;
          end
          default: begin
            w_state_nxt[i]   = WAIT_SYNC;
            w_low_cnt_nxt[i] = '0;
          end
        endcase
      end
      // Status is held while a low run is still unclassified.
      w_synced_nxt[i] = (w_state_nxt[i] == SYNCED) || (w_state_nxt[i] == LOW_PENDING);
      if (bus.err_cnt_clr) begin
        w_err_cnt_nxt[i] = w_err[i] ? ERR_ONE : '0;
      end else if (w_err[i] && (r_err_cnt[i] != ERR_MAX)) begin
        w_err_cnt_nxt[i] = r_err_cnt[i] + ERR_ONE;
      end else begin
        w_err_cnt_nxt[i] = r_err_cnt[i];
      end
    end
  end

  // State, counter and registered output update.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NUM_LINKS; i++) begin
        r_state[i]   <= WAIT_SYNC;
        r_low_cnt[i] <= '0;
        r_err_cnt[i] <= '0;
      end
      r_link_synced <= '0;
      r_resync_req  <= '0;
      r_err_pulse   <= '0;
      r_sync_all    <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_LINKS; i++) begin
        r_state[i]   <= w_state_nxt[i];
        r_low_cnt[i] <= w_low_cnt_nxt[i];
        r_err_cnt[i] <= w_err_cnt_nxt[i];
      end
      r_link_synced <= w_synced_nxt;
      r_resync_req  <= w_resync;
      r_err_pulse   <= w_err;
      r_sync_all    <= &r_link_synced;
    end
  end

  assign bus.link_synced = r_link_synced;
  assign bus.sync_all    = r_sync_all;
  assign bus.resync_req  = r_resync_req;
  assign bus.err_pulse   = r_err_pulse;

  for (genvar g = 0; g < NUM_LINKS; g++) begin : g_err_cnt
    assign bus.err_cnt[g*ERR_CNT_WIDTH +: ERR_CNT_WIDTH] = r_err_cnt[g];
  end

endmodule

// File: tb/tb_jesd204_tx_sync_monitor.sv
// Self-checking bench for jesd204_tx_sync_monitor: two links, 16-cycle resync threshold,
// 2-bit error counters, checked against a run-length reference model.
module tb_jesd204_tx_sync_monitor;

  localparam int NL = 2;
  localparam int R  = 16;
  localparam int W  = 2;
  localparam int CMAX = (1 << W) - 1;

  logic clk;
  logic resetn;

  jesd204_tx_sync_monitor_if #(.NUM_LINKS(NL), .ERR_CNT_WIDTH(W)) bus ();

  jesd204_tx_sync_monitor #(
    .NUM_LINKS(NL), .RESYNC_CYCLES(R), .ERR_CNT_WIDTH(W)
  ) dut (
    .clk(clk), .resetn(resetn), .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: per link, whether a high has been seen since enable/reset, and the length
  // of the current low run since then. Synced means seen-high and run shorter than R.
  int          have [NL];
  int          run  [NL];
  int          cnt  [NL];
  logic [NL-1:0] e_ls, e_rr, e_ep;
  logic        e_all;

  task automatic model_reset();
    for (int i = 0; i < NL; i++) begin
      have[i] = 0; run[i] = 0; cnt[i] = 0;
    end
    e_ls = '0; e_rr = '0; e_ep = '0; e_all = 1'b0;
  endtask

  task automatic model_step(input logic en, input logic [NL-1:0] s, input logic clr);
    e_all = &e_ls;
    for (int i = 0; i < NL; i++) begin
      e_rr[i] = 1'b0;
      e_ep[i] = 1'b0;
      if (!en) begin
        have[i] = 0; run[i] = 0;
      end else if (s[i]) begin
        if (have[i] != 0 && run[i] > 0 && run[i] < R) e_ep[i] = 1'b1;
        have[i] = 1; run[i] = 0;
      end else if (have[i] != 0) begin
        run[i] = run[i] + 1;
        if (run[i] == R) e_rr[i] = 1'b1;
      end
      e_ls[i] = (have[i] != 0) && (run[i] < R);
      if (clr) cnt[i] = 0;
      if (e_ep[i]) cnt[i] = (cnt[i] < CMAX) ? cnt[i] + 1 : CMAX;
    end
  endtask

  function automatic logic [10:0] exp_vec();
    logic [1:0] c0, c1;
    c0 = cnt[0][1:0];
    c1 = cnt[1][1:0];
    return {e_ls, e_all, e_rr, e_ep, c1, c0};
  endfunction

  function automatic logic [10:0] obs_vec();
    return {bus.link_synced, bus.sync_all, bus.resync_req, bus.err_pulse, bus.err_cnt};
  endfunction

  task automatic step(input logic en, input logic [NL-1:0] s, input logic clr);
    @(negedge clk);
    bus.enable      = en;
    bus.sync_n      = s;
    bus.err_cnt_clr = clr;
    model_step(en, s, clr);
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    resetn = 1'b0;
    bus.enable = 1'b0;
    bus.err_cnt_clr = 1'b0;
    model_reset();
    #1;
  endtask

  task automatic release_reset();
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (obs_vec() !== 11'b0) begin
      n_bad++;
      $display("FAIL reset: got %b want %b", obs_vec(), 11'b0);
    end
    release_reset();
  endtask

  task automatic test_cgs();
    int pulses = 0;
    for (int k = 0; k < 20; k++) begin
      step(1'b1, 2'b00, 1'b0);
      pulses += $countones({bus.resync_req, bus.err_pulse});
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin
        n_bad++;
        $display("FAIL cgs_low k=%0d: got %b want %b", k, obs_vec(), exp_vec());
      end
    end
    step(1'b1, 2'b11, 1'b0);
    n_cmp++;
    if ({bus.link_synced, bus.sync_all} !== 3'b110 || pulses != 0) begin
      n_bad++;
      $display("FAIL cgs_first_high: got ls/all %b pulses %0d want 110 pulses 0",
               {bus.link_synced, bus.sync_all}, pulses);
    end
    step(1'b1, 2'b11, 1'b0);
    n_cmp++;
    if (bus.sync_all !== 1'b1 || obs_vec() !== exp_vec()) begin
      n_bad++;
      $display("FAIL cgs_sync_all: got %b want %b", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_short();
    for (int k = 0; k < 5; k++) begin
      step(1'b1, (k < 3) ? 2'b00 : 2'b11, 1'b0);
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin
        n_bad++;
        $display("FAIL short k=%0d: got %b want %b", k, obs_vec(), exp_vec());
      end
      if (k == 3) begin
        n_cmp++;
        if (bus.err_pulse !== 2'b11 || bus.err_cnt !== 4'b0101 || bus.link_synced !== 2'b11) begin
          n_bad++;
          $display("FAIL short_err: got ep %b cnt %b ls %b want 11 0101 11",
                   bus.err_pulse, bus.err_cnt, bus.link_synced);
        end
      end
    end
  endtask

  task automatic test_long();
    int lens[3] = '{15, 16, 40};
    for (int t = 0; t < 3; t++) begin
      int rr_seen = 0;
      for (int k = 0; k <= lens[t] + 1; k++) begin
        step(1'b1, (k < lens[t]) ? 2'b10 : 2'b11, 1'b0);
        rr_seen += int'(bus.resync_req[0]);
        n_cmp++;
        if (obs_vec() !== exp_vec()) begin
          n_bad++;
          $display("FAIL long L=%0d k=%0d: got %b want %b", lens[t], k, obs_vec(), exp_vec());
        end
        if (k == R - 1 && lens[t] >= R) begin
          n_cmp++;
          if (bus.resync_req[0] !== 1'b1 || bus.link_synced[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL long_edge L=%0d: got rr %b ls %b want 1 0",
                     lens[t], bus.resync_req[0], bus.link_synced[0]);
          end
        end
      end
      n_cmp++;
      if (rr_seen != ((lens[t] >= R) ? 1 : 0)) begin
        n_bad++;
        $display("FAIL long_count L=%0d: got %0d resync pulses want %0d",
                 lens[t], rr_seen, (lens[t] >= R) ? 1 : 0);
      end
    end
  endtask

  task automatic test_saturate();
    int sat_seq[5] = '{1, 2, 3, 3, 3};
    int ep_seen = 0;
    apply_reset();
    release_reset();
    repeat (2) step(1'b1, 2'b11, 1'b0);
    for (int e = 0; e < 6; e++) begin
      step(1'b1, 2'b10, 1'b0);
      step(1'b1, 2'b10, 1'b0);
      step(1'b1, 2'b11, (e == 5) ? 1'b1 : 1'b0);
      ep_seen += int'(bus.err_pulse[0]);
      n_cmp++;
      if (bus.err_cnt[1:0] !== ((e == 5) ? 2'd1 : 2'(sat_seq[e])) || obs_vec() !== exp_vec()) begin
        n_bad++;
        $display("FAIL saturate e=%0d: got cnt %0d vec %b want cnt %0d vec %b", e,
                 bus.err_cnt[1:0], obs_vec(), (e == 5) ? 1 : sat_seq[e], exp_vec());
      end
    end
    n_cmp++;
    if (ep_seen != 6) begin
      n_bad++;
      $display("FAIL saturate_pulses: got %0d want 6", ep_seen);
    end
  endtask

  task automatic test_two_links();
    for (int k = 0; k < 30; k++) begin
      logic [NL-1:0] s;
      s[0] = !(k >= 2 && k < 6);
      s[1] = !(k < 20);
      step(1'b1, s, 1'b0);
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin
        n_bad++;
        $display("FAIL two_links k=%0d: got %b want %b", k, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_abort();
    logic [3:0] cnt_keep;
    for (int k = 0; k < 10; k++) step(1'b1, 2'b10, 1'b0);
    apply_reset();
    n_cmp++;
    if (obs_vec() !== 11'b0) begin
      n_bad++;
      $display("FAIL abort_reset: got %b want %b", obs_vec(), 11'b0);
    end
    release_reset();
    repeat (2) step(1'b1, 2'b11, 1'b0);
    step(1'b1, 2'b10, 1'b0);
    step(1'b1, 2'b11, 1'b0);
    cnt_keep = bus.err_cnt;
    for (int k = 0; k < 10; k++) step(1'b1, 2'b10, 1'b0);
    step(1'b0, 2'b11, 1'b0);
    n_cmp++;
    if (bus.err_cnt !== 4'b0001 || cnt_keep !== 4'b0001 ||
        {bus.link_synced, bus.resync_req, bus.err_pulse} !== 6'b0 || obs_vec() !== exp_vec()) begin
      n_bad++;
      $display("FAIL abort_enable: got %b want %b", obs_vec(), exp_vec());
    end
    step(1'b1, 2'b00, 1'b0);
    n_cmp++;
    if (obs_vec() !== exp_vec()) begin
      n_bad++;
      $display("FAIL abort_wait: got %b want %b", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_random();
    logic [NL-1:0] s = 2'b11;
    logic en, clr;
    for (int k = 0; k < 600; k++) begin
      for (int i = 0; i < NL; i++) begin
        if ($urandom_range(0, 9) == 0) s[i] = ~s[i];
      end
      en  = ($urandom_range(0, 59) != 0);
      clr = ($urandom_range(0, 49) == 0);
      step(en, s, clr);
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin
        n_bad++;
        $display("FAIL random k=%0d: got %b want %b", k, obs_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    resetn = 1'b0;
    bus.enable = 1'b0;
    bus.sync_n = 2'b11;
    bus.err_cnt_clr = 1'b0;
    model_reset();
    test_reset();
    test_cgs();
    test_short();
    test_long();
    test_saturate();
    test_two_links();
    test_abort();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
